seq1011_moore_det: RTL and testbench
====================================

Name: seq1011_moore_det

Overview:
- Moore-type serial sequence detector for the bit pattern 1-0-1-1, with overlapping detection.
- Samples one serial input bit per clock and raises a one-cycle flag while the FSM sits in the "pattern complete" state.
- Used as a leaf block behind the team's fsm1011 interface bundle (clk, x, y, rst).
- Output depends only on the current state, never directly on x.

Parameters:
- CNT_W, 8, width of the optional match counter (used only when FSM1011_MATCH_CNT_EN is defined).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high; forces state S0.
- x  input  1  serial data bit, sampled on rising clk.
- y  output  1  detect flag; 1 only while state == S4.
- match_cnt  output  CNT_W  matches detected; port exists only with FSM1011_MATCH_CNT_EN.

Behaviour:
- State register ps, 3 bits. Encoding: S0=000 (idle), S1=001 (seen 1), S2=010 (seen 10), S3=011 (seen 101), S4=100 (seen 1011, detect).
- Reset: rst=1 drives ps=S0 immediately, without waiting for a clock edge. y=0 while rst is high and after release until a new full match.
- Next-state logic is combinational from ps and x. The register loads it on each rising clk when rst=0.
  - S0: x=1 -> S1; x=0 -> S0.
  - S1: x=1 -> S1; x=0 -> S2.
  - S2: x=1 -> S3; x=0 -> S0.
  - S3: x=1 -> S4; x=0 -> S2.
  - S4: x=1 -> S1; x=0 -> S2. This is the overlap: a trailing 1 or "10" is reused as a prefix.
  - Illegal codes 101/110/111: next state S0 regardless of x. y=0 in illegal codes.
- Output: y = (ps == S4), decoded combinationally from the registered state only. It is glitch-free with respect to x.
- Latency: y rises in the cycle after the rising edge that samples the final '1' of the pattern. It stays high exactly one clock period unless re-entered; S4 cannot go directly to S4.
- Minimum spacing between two detections: 3 clocks (pattern 1011011).
- x changing mid-cycle has no effect on y. Only the value at the rising clk edge matters.
- rst asserted mid-sequence discards the partial match. Detection restarts from S0 after release.
- No enable and no handshake. Every clock edge consumes one bit.

Optional Feature:
- Macro FSM1011_MATCH_CNT_EN.
- When defined:
  - Adds output match_cnt[CNT_W-1:0].
  - The counter increments on each rising clk where the next state is S4, i.e. it is aligned with y rising.
  - It saturates at all-ones.
  - It is cleared asynchronously by rst.
- When undefined: no counter logic and no match_cnt port. The rest of the behaviour is identical.

Test Plan:
- Reset check: assert rst mid-cycle with clk idle -> ps=S0 and y=0 immediately. Release rst and hold x=0 for 10 clocks -> y stays 0.
- Basic match: x = 1,0,1,1 on four consecutive edges -> y=0 through edge 3, y=1 after edge 4 for exactly one cycle. With the feature enabled, match_cnt=1.
- Overlap: x = 1,0,1,1,0,1,1 -> y pulses after edge 4 and after edge 7, 3 cycles apart. With the feature enabled, match_cnt=2.
- Near misses: x = 1,0,0,1,0,1,1 -> single pulse after edge 7 only. x = 1,1,1,0,1,1 -> single pulse after edge 6. x = 1,0,1,0,1,1 -> single pulse after edge 6 (S3 with x=0 goes to S2).
- Reset mid-operation: x = 1,0,1, then pulse rst between edges, then x=1 -> no pulse. Then x = 0,1,1 -> pulse (the post-reset 1 plus 0,1,1 forms 1011).
- Illegal state: force ps=111 via backdoor -> y=0, ps=S0 after the next edge for x=0 and for x=1.

Source files
------------

// File: rtl/seq1011_moore_det.sv
// Moore detector for serial pattern 1011 with overlap; optional saturating match counter (FSM1011_MATCH_CNT_EN).
// Latency: y rises one cycle after the edge that samples the final 1. Backpressure: none, one bit consumed per clk.
module seq1011_moore_det
`ifdef FSM1011_MATCH_CNT_EN
#(
    parameter int CNT_W = 8
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
`ifdef FSM1011_MATCH_CNT_EN
    output logic [CNT_W-1:0] match_cnt,
`endif
    output logic             y
);

    typedef enum logic [2:0] {
        S0 = 3'b000,
        S1 = 3'b001,
        S2 = 3'b010,
        S3 = 3'b011,
        S4 = 3'b100
    } state_e;

    // Kept as a plain vector so the three unused codes remain representable.
    logic [2:0] ps_q;
    logic [2:0] ps_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= S0;
        end else begin
            ps_q <= ps_d;
        end
    end

    always_comb begin
        ps_d = S0;
        y    = 1'b0;
        case (ps_q)
            S0: ps_d = x ? S1 : S0;
            S1: ps_d = x ? S1 : S2;
            S2: ps_d = x ? S3 : S0;
            S3: ps_d = x ? S4 : S2;
            S4: begin
                y    = 1'b1;
                // A trailing 1 or 10 is reused as the prefix of the next match.
                ps_d = x ? S1 : S2;
            end
            default: ps_d = S0;
        endcase
    end

`ifdef FSM1011_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((ps_d == S4) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq1011_moore_det.sv
// Bench for seq1011_moore_det: directed pattern cases plus random bits against a suffix-matching model.
module tb_seq1011_moore_det;

    logic clk = 1'b0;
    logic rst;
    logic x;
    logic y;
`ifdef FSM1011_MATCH_CNT_EN
    logic [7:0] match_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Model: every bit accepted since the last reset; a match is the last four equal to 1011.
    int hist;
    int nbits;
    int mcnt;

    seq1011_moore_det dut (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
`ifdef FSM1011_MATCH_CNT_EN
        .match_cnt (match_cnt),
`endif
        .y         (y)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_y();
        return (nbits >= 4) && ((hist & 15) == 4'b1011);
    endfunction

    // Called at a falling edge; holds reset across one rising edge and releases on the next fall.
    task automatic do_reset();
        rst   = 1'b1;
        hist  = 0;
        nbits = 0;
        mcnt  = 0;
        #1;
        check("rst_y", {31'd0, y}, 32'd0);
        check("rst_ps", {29'd0, dut.ps_q}, 32'd0);
`ifdef FSM1011_MATCH_CNT_EN
        check("rst_cnt", {24'd0, match_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic b, output logic yo);
        x = b;
        @(posedge clk);
        hist  = (hist << 1) | int'(b);
        nbits = nbits + 1;
        if (model_y() && mcnt < 255) mcnt = mcnt + 1;
        #1;
        check("y", {31'd0, y}, {31'd0, model_y()});
`ifdef FSM1011_MATCH_CNT_EN
        check("match_cnt", {24'd0, match_cnt}, mcnt);
`endif
        yo = y;
        @(negedge clk);
    endtask

    // bits[n-1] is applied first; mask bit i records y after step i.
    task automatic run_seq(input string tag, input logic [15:0] bits, input int n,
                           input logic [15:0] exp_mask);
        logic [15:0] mask;
        logic        yo;
        mask = '0;
        for (int i = 0; i < n; i++) begin
            step(bits[n-1-i], yo);
            mask[i] = yo;
        end
        check(tag, {16'd0, mask}, {16'd0, exp_mask});
    endtask

    initial begin
        logic yo;
        rst = 1'b1;
        x   = 1'b0;
        @(negedge clk);
        do_reset();

        run_seq("idle_zeros", 16'h0000, 10, 16'h0000);

        run_seq("basic", 16'b1011, 4, 16'h0008);
        check("in_s4", {31'd0, y}, 32'd1);
        // Asynchronous reset with the DUT sitting in the detect state.
        do_reset();

        run_seq("overlap", 16'b1011011, 7, 16'h0048);
        do_reset();
        run_seq("miss_1001011", 16'b1001011, 7, 16'h0040);
        do_reset();
        run_seq("miss_111011", 16'b111011, 6, 16'h0020);
        do_reset();
        run_seq("miss_101011", 16'b101011, 6, 16'h0020);

        do_reset();
        run_seq("pre_rst_101", 16'b101, 3, 16'h0000);
        do_reset();
        run_seq("post_rst_1011", 16'b1011, 4, 16'h0008);

        // Unused state codes must decode y=0 and return to S0 for either x.
        force dut.ps_q = 3'b111;
        x = 1'b0;
        #1;
        check("ill7_y", {31'd0, y}, 32'd0);
        check("ill7_nx0", {29'd0, dut.ps_d}, 32'd0);
        x = 1'b1;
        #1;
        check("ill7_nx1", {29'd0, dut.ps_d}, 32'd0);
        force dut.ps_q = 3'b101;
        #1;
        check("ill5_y", {31'd0, y}, 32'd0);
        check("ill5_nx1", {29'd0, dut.ps_d}, 32'd0);
        force dut.ps_q = 3'b110;
        x = 1'b0;
        #1;
        check("ill6_nx0", {29'd0, dut.ps_d}, 32'd0);
        release dut.ps_q;
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), yo);
            end
        end

`ifdef FSM1011_MATCH_CNT_EN
        do_reset();
        for (int i = 0; i < 270; i++) begin
            run_seq("rep_1011", 16'b1011, 4, 16'h0008);
        end
        check("cnt_sat", {24'd0, match_cnt}, 32'd255);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
